// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM encoding and datapath widths for the multiplier arbiter
// Ports: none (package)
package mul_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;
    localparam int MUL_W = 32;
    localparam int PROD_W = 64;
endpackage

// File: rtl/Mul32.sv
// Mul32: combinational unsigned 32x32 -> 64 multiplier
// Ports: a, b (in 32) operands; p (out 64) full product
module Mul32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    assign p = 64'(a) * 64'(b);
endmodule

// File: rtl/rr_grant.sv
// rr_grant: rotating priority picker, first requester at or after ptr wins
// Ports: req (in N) requests; ptr (in IDW) search start; gnt (out N) one-hot grant;
//        idx (out IDW) granted index; any (out) at least one request present
module rr_grant #(
    parameter int N = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] idx,
    output logic           any
);
    logic [IDW-1:0] p;
    // walk from lowest to highest priority so the last hit is the winner
    always_comb begin
        gnt = '0;
        idx = '0;
        p = '0;
        for (int k = N - 1; k >= 0; k--) begin
            p = IDW'((int'(ptr) + k) % N);
            if (req[p]) begin
                gnt = '0;
                gnt[p] = 1'b1;
                idx = p;
            end
        end
    end
    assign any = |req;
endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one multicycle Mul32 among NREQ valid/ready requesters
// Ports: clk, rst (async, active-high); req_valid/req_ready (NREQ) request handshake;
//        req_a/req_b (NREQ*32) packed operands; rsp_valid/rsp_ready response handshake;
//        rsp_id (IDW) owner of rsp_data; rsp_data (64) unsigned product
// Config: define MUL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW = 1,
    parameter int MUL_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*MUL_W-1:0]  req_a,
    input  logic [NREQ*MUL_W-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [PROD_W-1:0]      rsp_data
);
    localparam int CW = MUL_CYCLES > 1 ? $clog2(MUL_CYCLES) : 1;
    state_t state;
    logic [CW-1:0] cnt;
    logic [MUL_W-1:0] op_a, op_b;
    logic [IDW-1:0] op_id, start, gidx;
    logic [NREQ-1:0] gnt;
    logic any, accept;
    logic [PROD_W-1:0] prod;
    assign accept = state == IDLE && any;
`ifdef MUL_ARB_FIXED_PRIO_EN
    assign start = '0;
`else
    logic [IDW-1:0] rr_ptr;
    assign start = rr_ptr;
    always_ff @(posedge clk or posedge rst)
        if (rst) rr_ptr <= '0;
        else if (accept) rr_ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
`endif
    rr_grant #(.N(NREQ), .IDW(IDW)) u_grant (
        .req (req_valid),
        .ptr (start),
        .gnt (gnt),
        .idx (gidx),
        .any (any)
    );
    // gated by rst so a requester never sees ready while reset holds the FSM
    assign req_ready = (state == IDLE && !rst) ? gnt : '0;
    assign rsp_valid = state == RESP;
    // operands sit in op_a/op_b for MUL_CYCLES cycles before capture
    Mul32 u_mul (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            op_a <= '0;
            op_b <= '0;
            op_id <= '0;
            rsp_id <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_a <= req_a[MUL_W*gidx +: MUL_W];
                    op_b <= req_b[MUL_W*gidx +: MUL_W];
                    op_id <= gidx;
                    cnt <= CW'(MUL_CYCLES - 1);
                    state <= CALC;
                end
                CALC: if (cnt == '0) begin
                    rsp_data <= prod;
                    rsp_id <= op_id;
                    state <= RESP;
                end else cnt <= cnt - 1'b1;
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed bench with a transaction-level model checked every cycle
module tb_mul_arbiter;
    localparam int NREQ = 2, IDW = 1, MC = 2;
`ifdef MUL_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ*32-1:0] req_a = '0, req_b = '0;
    logic rsp_ready = 1'b0;
    logic [NREQ-1:0] req_ready;
    logic rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [63:0] rsp_data;
    int vectors = 0, miscompares = 0;
    bit m_busy = 0, m_valid = 0;
    int m_age = 0, m_ptr = 0, m_id = 0, m_rid = 0;
    bit [31:0] m_a = 0, m_b = 0;
    bit [63:0] m_rdata = 0;
    int glog[$];

    mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 0; m_valid = 0; m_age = 0; m_ptr = 0; m_id = 0;
            m_rid = 0; m_rdata = 0; m_a = 0; m_b = 0;
        end else if (m_valid) begin
            if (rsp_ready) m_valid = 0;
        end else if (m_busy) begin
            m_age++;
            if (m_age == MC) begin
                m_busy = 0; m_valid = 1; m_rid = m_id;
                m_rdata = 64'(m_a) * 64'(m_b);
            end
        end else begin
            int w;
            w = winner(req_valid, FIXED ? 0 : m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_age = 0; m_id = w;
                m_a = req_a[32*w +: 32]; m_b = req_b[32*w +: 32];
                m_ptr = (w + 1) % NREQ;
            end
        end
    end

    initial forever begin
        int w;
        logic [NREQ-1:0] er;
        @(negedge clk);
        er = '0;
        w = winner(req_valid, FIXED ? 0 : m_ptr);
        if (!m_busy && !m_valid && !rst && w >= 0) er[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        chk("rsp_id", 64'(rsp_id), 64'(m_rid));
        chk("rsp_data", rsp_data, m_rdata);
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) glog.push_back(k);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic wait_accept(input int i);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = req_ready[i];
            tick();
            n++;
        end
        req_valid[i] = 1'b0;
        chk("accept", 64'(acc), 64'd1);
    endtask

    task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic rr, output int lat);
        set_op(i, a, b);
        rsp_ready = rr;
        req_valid[i] = 1'b1;
        wait_accept(i);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int exp_g;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        tick();

        single(0, 32'h100, 32'h10, 1'b1, lat);
        chk("t1_latency", 64'(lat), 64'd3);
        chk("t1_id", 64'(rsp_id), 64'd0);
        chk("t1_data", rsp_data, 64'h1000);
        tick();
        chk("t1_done", 64'(rsp_valid), 64'd0);

        single(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat);
        chk("t2_data", rsp_data, 64'hFFFFFFFE00000001);
        tick();

        rst = 1'b1;
        req_valid = 2'b11;
        set_op(0, 32'd2, 32'd3);
        set_op(1, 32'd4, 32'd5);
        rsp_ready = 1'b1;
        tick();
        glog.delete();
        rst = 1'b0;
        repeat (18) tick();
        req_valid = '0;
        repeat (6) tick();
        chk("t3_grant_count", 64'(glog.size() >= 4), 64'd1);
        for (int k = 0; k < 4; k++) begin
            exp_g = FIXED ? 0 : k % 2;
            chk("t3_grant_order", 64'(k < glog.size() ? glog[k] : -1), 64'(exp_g));
        end

        single(0, 32'd7, 32'd9, 1'b0, lat);
        req_valid[1] = 1'b1;
        set_op(1, 32'h20, 32'h3);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t4_hold_id", 64'(rsp_id), 64'd0);
            chk("t4_hold_data", rsp_data, 64'd63);
            chk("t4_hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("t4_released", 64'(rsp_valid), 64'd0);
        chk("t4_idle_ready", 64'(req_ready), 64'b10);
        tick();
        req_valid[1] = 1'b0;
        repeat (5) tick();
        chk("t4_next_data", rsp_data, 64'h60);

        set_op(0, 32'd3, 32'd5);
        req_valid[0] = 1'b1;
        wait_accept(0);
        tick();
        #1 rst = 1'b1;
        #1;
        chk("t5_async_valid", 64'(rsp_valid), 64'd0);
        chk("t5_async_id", 64'(rsp_id), 64'd0);
        chk("t5_async_data", rsp_data, 64'd0);
        chk("t5_async_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
        end
        set_op(0, 32'd6, 32'd7);
        set_op(1, 32'd8, 32'd9);
        req_valid = 2'b11;
        #1;
        chk("t5_ptr_reset", 64'(req_ready), 64'b01);
        wait_accept(0);
        req_valid[1] = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("t5_id", 64'(rsp_id), 64'd0);
        chk("t5_data", rsp_data, 64'd42);
        tick();

        single(0, 32'h0, 32'h10, 1'b1, lat);
        chk("t6_zero_a", rsp_data, 64'd0);
        tick();
        single(1, 32'h10, 32'h0, 1'b1, lat);
        chk("t6_zero_b", rsp_data, 64'd0);
        chk("t6_zero_b_id", 64'(rsp_id), 64'd1);
        tick();
        single(1, 32'h10, 32'h10, 1'b1, lat);
        chk("t6_data", rsp_data, 64'h100);
        chk("t6_id", 64'(rsp_id), 64'd1);
        tick();
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
